// File: rtl/gaplus_pcm_player_if.sv
// Signal bundle between the PCM player, its sample ROM, the I/O kick source and the mixer.
interface gaplus_pcm_player_if #(
  parameter int ADDR_W = 13
);
  logic                     kick;
  logic [1:0]               vol;
  logic [ADDR_W-1:0]        rom_ad;
  logic [7:0]               rom_rd;
  logic                     busy;
  logic signed [15:0]       pcm_out;

  modport slave (
    input  kick, vol, rom_rd,
    output rom_ad, busy, pcm_out
  );

  modport master (
    output kick, vol, rom_rd,
    input  rom_ad, busy, pcm_out
  );
endinterface

// File: rtl/gaplus_pcm_player.sv
// Edge-triggered sample playback: streams LEN unsigned ROM bytes at one sample per DIV clocks
// and presents them to the mixer as attenuated signed 16-bit PCM.
module gaplus_pcm_player #(
  parameter int ADDR_W = 13,
  parameter int LEN    = 8192,
  parameter int DIV    = 4800
) (
  input  logic             clk,
  input  logic             reset,
  gaplus_pcm_player_if.slave bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_AD  = ADDR_W'(LEN - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, WAIT} state_t;

  state_t             state_p0, state_nxt;
  logic               kick_p0;
  logic [ADDR_W-1:0]  addr_p0, addr_nxt;
  logic [DIV_W-1:0]   div_p0, div_nxt;
  logic               busy_p0, busy_nxt;
  logic signed [15:0] pcm_p1, pcm_nxt;
  logic               start;
  logic               wrap;

  // Offset-binary byte to signed 16-bit, then attenuate by an arithmetic shift.
  function automatic logic signed [15:0] to_pcm(input logic [7:0] raw, input logic [1:0] shift);
    logic signed [15:0] s;
    s = {~raw[7], raw[6:0], 8'h00};
    return s >>> shift;
  endfunction

  assign start = bus.kick & ~kick_p0;
  assign wrap  = busy_p0 && (div_p0 == DIV_LAST);

  always_comb begin
    state_nxt = state_p0;
    addr_nxt  = addr_p0;
    busy_nxt  = busy_p0;
    pcm_nxt   = pcm_p1;
    div_nxt   = '0;
    if (busy_p0 && !wrap) div_nxt = div_p0 + DIV_W'(1);

    case (state_p0)
      FETCH: state_nxt = LATCH;
      LATCH: begin
        pcm_nxt   = to_pcm(bus.rom_rd, bus.vol);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wrap) begin
          if (addr_p0 == LAST_AD) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            pcm_nxt   = '0;
            addr_nxt  = '0;
          end else begin
            addr_nxt  = addr_p0 + ADDR_W'(1);
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new kick edge overrides everything, including a coincident final wrap;
    // the previous sample stays on the output until the new one is latched.
    if (start) begin
      state_nxt = FETCH;
      addr_nxt  = '0;
      div_nxt   = '0;
      busy_nxt  = 1'b1;
      pcm_nxt   = pcm_p1;
    end
  end

  // Stage p0: control state, address and divider; stage p1: output sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
      kick_p0  <= 1'b0;
      addr_p0  <= '0;
      div_p0   <= '0;
      busy_p0  <= 1'b0;
      pcm_p1   <= '0;
    end else begin
      state_p0 <= state_nxt;
      kick_p0  <= bus.kick;
      addr_p0  <= addr_nxt;
      div_p0   <= div_nxt;
      busy_p0  <= busy_nxt;
      pcm_p1   <= pcm_nxt;
    end
  end

  assign bus.rom_ad  = addr_p0;
  assign bus.busy    = busy_p0;
  assign bus.pcm_out = pcm_p1;

endmodule

// File: tb/tb_gaplus_pcm_player.sv
// Bench for gaplus_pcm_player: two instances (LEN=4 and full 3-bit address space) with
// cycle-stamped expectations held in a scoreboard queue.
module tb_gaplus_pcm_player;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gaplus_pcm_player_if #(.ADDR_W(13)) bus_a ();
  gaplus_pcm_player_if #(.ADDR_W(3))  bus_b ();

  gaplus_pcm_player #(.ADDR_W(13), .LEN(4), .DIV(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  gaplus_pcm_player #(.ADDR_W(3), .LEN(8), .DIV(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic [7:0] rom_a [0:15];
  logic [7:0] rom_b [0:7];

  always_ff @(posedge clk) begin
    bus_a.rom_rd <= rom_a[bus_a.rom_ad[3:0]];
    bus_b.rom_rd <= rom_b[bus_b.rom_ad];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          at;
    bit          sel;
    logic [15:0] pcm;
    logic        busy;
    logic [12:0] ad;
    string       name;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  raw;
    logic [1:0]  vol;
    logic [15:0] exp;
  } vec_t;

  task automatic expect_at(input int ofs, input bit sel, input logic [15:0] pcm,
                           input logic busy, input logic [12:0] ad, input string name);
    exp_t e;
    e.at = cyc + ofs; e.sel = sel; e.pcm = pcm; e.busy = busy; e.ad = ad; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic check_entry(input exp_t e);
    logic [15:0] p;
    logic        b;
    logic [12:0] a;
    if (!e.sel) begin
      p = bus_a.pcm_out; b = bus_a.busy; a = bus_a.rom_ad;
    end else begin
      p = bus_b.pcm_out; b = bus_b.busy; a = {10'd0, bus_b.rom_ad};
    end
    checks++;
    if (p !== e.pcm || b !== e.busy || a !== e.ad) begin
      errors++;
      $display("FAIL %s @cyc %0d: got pcm=%h busy=%b ad=%0d, want pcm=%h busy=%b ad=%0d",
               e.name, cyc, p, b, a, e.pcm, e.busy, e.ad);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at <= cyc) begin
        check_entry(sbq[i]);
        sbq.delete(i);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 2000) begin
      tick(1);
      k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{8'h00, 2'd1, 16'hC000};
    vt[1] = '{8'h00, 2'd3, 16'hF000};
    vt[2] = '{8'hFF, 2'd2, 16'h1FC0};
    vt[3] = '{8'h80, 2'd0, 16'h0000};
    vt[4] = '{8'hC0, 2'd1, 16'h2000};
    vt[5] = '{8'h7F, 2'd3, 16'hFFE0};
    vt[6] = '{8'h01, 2'd2, 16'hE040};

    bus_a.kick = 1'b0; bus_a.vol = 2'd0;
    bus_b.kick = 1'b0; bus_b.vol = 2'd0;
    for (int i = 0; i < 16; i++) rom_a[i] = 8'h80;
    rom_a[0] = 8'h80; rom_a[1] = 8'hFF; rom_a[2] = 8'h00; rom_a[3] = 8'hC0;
    for (int i = 0; i < 8; i++) rom_b[i] = 8'h80 + 8'(16 * i);

    // Reset state
    #2;
    chk("reset busy_a", 32'(bus_a.busy), 32'd0);
    chk("reset pcm_a",  32'(bus_a.pcm_out), 32'd0);
    chk("reset ad_a",   32'(bus_a.rom_ad), 32'd0);
    chk("reset busy_b", 32'(bus_b.busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // Test 1: basic playback with a long kick
    bus_a.kick = 1'b1;
    expect_at(1,   0, 16'h0000, 1'b1, 13'd0, "t1 C1");
    expect_at(3,   0, 16'h0000, 1'b1, 13'd0, "t1 s0");
    expect_at(7,   0, 16'h7F00, 1'b1, 13'd1, "t1 s1");
    expect_at(11,  0, 16'h8000, 1'b1, 13'd2, "t1 s2");
    expect_at(15,  0, 16'h4000, 1'b1, 13'd3, "t1 s3");
    expect_at(16,  0, 16'h4000, 1'b1, 13'd3, "t1 last busy");
    expect_at(17,  0, 16'h0000, 1'b0, 13'd0, "t1 end");
    expect_at(100, 0, 16'h0000, 1'b0, 13'd0, "t1 no retrig");
    expect_at(510, 0, 16'h0000, 1'b0, 13'd0, "t1 no retrig late");
    tick(511);
    bus_a.kick = 1'b0;
    drain();

    // Test 2: attenuation table, sample 0 of each effect
    for (int i = 0; i < 7; i++) begin
      bus_a.kick = 1'b0;
      tick(2);
      rom_a[0]  = vt[i].raw;
      bus_a.vol = vt[i].vol;
      bus_a.kick = 1'b1;
      expect_at(3, 0, vt[i].exp, 1'b1, 13'd0, $sformatf("t2 vec%0d", i));
      tick(4);
    end
    bus_a.kick = 1'b0;
    bus_a.vol  = 2'd0;
    rom_a[0]   = 8'h80;
    tick(20);

    // vol is sampled only when a sample is latched
    bus_a.kick = 1'b1;
    expect_at(7, 0, 16'h7F00, 1'b1, 13'd1, "vol s1");
    tick(8);
    bus_a.vol = 2'd2;
    expect_at(1, 0, 16'h7F00, 1'b1, 13'd2, "vol hold");
    expect_at(3, 0, 16'hE000, 1'b1, 13'd2, "vol s2");
    drain();
    bus_a.kick = 1'b0;
    bus_a.vol  = 2'd0;
    tick(20);

    // Test 3: retrigger after the second sample
    bus_a.kick = 1'b1;
    expect_at(3, 0, 16'h0000, 1'b1, 13'd0, "t3 s0");
    expect_at(7, 0, 16'h7F00, 1'b1, 13'd1, "t3 s1");
    tick(6);
    bus_a.kick = 1'b0;
    tick(2);
    bus_a.kick = 1'b1;
    expect_at(1,  0, 16'h7F00, 1'b1, 13'd0, "t3 R+1");
    expect_at(2,  0, 16'h7F00, 1'b1, 13'd0, "t3 R+2");
    expect_at(3,  0, 16'h0000, 1'b1, 13'd0, "t3 R+3");
    expect_at(9,  0, 16'h7F00, 1'b1, 13'd2, "t3 old end");
    expect_at(16, 0, 16'h4000, 1'b1, 13'd3, "t3 last busy");
    expect_at(17, 0, 16'h0000, 1'b0, 13'd0, "t3 end");
    tick(2);
    bus_a.kick = 1'b0;
    drain();
    tick(4);

    // Test 4: start on the same cycle as the final wrap
    rom_a[0] = 8'h00;
    bus_a.kick = 1'b1;
    expect_at(3,  0, 16'h8000, 1'b1, 13'd0, "t4 s0");
    expect_at(15, 0, 16'h4000, 1'b1, 13'd3, "t4 s3");
    tick(1);
    bus_a.kick = 1'b0;
    tick(15);
    bus_a.kick = 1'b1;
    expect_at(1,  0, 16'h4000, 1'b1, 13'd0, "t4 busy kept");
    expect_at(3,  0, 16'h8000, 1'b1, 13'd0, "t4 replay");
    expect_at(16, 0, 16'h4000, 1'b1, 13'd3, "t4 last busy");
    expect_at(17, 0, 16'h0000, 1'b0, 13'd0, "t4 end");
    tick(1);
    bus_a.kick = 1'b0;
    drain();
    tick(4);

    // Test 5: asynchronous reset mid-sample, kick high through release
    bus_a.kick = 1'b1;
    expect_at(3, 0, 16'h8000, 1'b1, 13'd0, "t5 s0");
    tick(5);
    #2;
    reset = 1'b1;
    #1;
    chk("t5 async busy", 32'(bus_a.busy), 32'd0);
    chk("t5 async pcm",  32'(bus_a.pcm_out), 32'd0);
    chk("t5 async ad",   32'(bus_a.rom_ad), 32'd0);
    tick(2);
    reset = 1'b0;
    expect_at(1, 0, 16'h0000, 1'b1, 13'd0, "t5 restart");
    expect_at(3, 0, 16'h8000, 1'b1, 13'd0, "t5 s0 again");
    tick(3);
    bus_a.kick = 1'b0;
    drain();
    rom_a[0] = 8'h80;

    // Test 6: full 3-bit address space ends on all-ones without wrapping
    bus_b.kick = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expect_at(1 + 4 * k, 1, (k == 0) ? 16'h0000 : 16'(4096 * (k - 1)), 1'b1, 13'(k), "t6 ad");
      expect_at(3 + 4 * k, 1, 16'(4096 * k), 1'b1, 13'(k), "t6 sample");
    end
    expect_at(32, 1, 16'h7000, 1'b1, 13'd7, "t6 last busy");
    expect_at(33, 1, 16'h0000, 1'b0, 13'd0, "t6 end");
    expect_at(45, 1, 16'h0000, 1'b0, 13'd0, "t6 no replay");
    tick(2);
    bus_b.kick = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
